// File: rtl/intr_pkg.sv
// Shared types and constants for the two-source interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package intr_pkg;

  // Service state. SRV1_OVER2 means source 1 has preempted source 2.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SRV2       = 2'd1,
    SRV1       = 2'd2,
    SRV1_OVER2 = 2'd3
  } state_e;

  // Bit positions of each source in the pending/mask/in_service vectors.
  localparam int SRC1 = 0;
  localparam int SRC2 = 1;

  // Default enable mask after reset: every source disabled.
  localparam logic [1:0] MASK_RST_DFLT = 2'b00;

  // Whether a source may be dispatched from the given service state.
  // Only source 1 can preempt, and only while source 2 is being serviced.
  function automatic logic src_allowed(state_e st, int src);
    logic ok;
    ok = 1'b0;
    case (st)
      IDLE:    ok = 1'b1;
      SRV2:    ok = (src == SRC1);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // in_service flags (bit0 = source 1) implied by the service state.
  function automatic logic [1:0] svc_of(state_e st);
    logic [1:0] v;
    v = 2'b00;
    case (st)
      IDLE:       v = 2'b00;
      SRV2:       v = 2'b10;
      SRV1:       v = 2'b01;
      SRV1_OVER2: v = 2'b11;
      default:    v = 2'b00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/intr_controller_if.sv
// Signal bundle between the control unit and the interrupt controller.
// Latency: n/a (wiring only).
// Backpressure: busy/reti from the control unit suppress dispatch for that cycle.
interface intr_controller_if;

  // Requests and control-unit status into the controller.
  logic       irq1;
  logic       irq2;
  logic       cfg_we;
  logic [1:0] cfg_data;
  logic       busy;
  logic       reti;

  // Dispatch strobes and status back to the control unit.
  logic       s_intr1;
  logic       s_intr2;
  logic       push_req;
  logic [1:0] pending;
  logic [1:0] in_service;
  logic [1:0] int_mask;
  logic       reti_err;

  // Control-unit side.
  modport master (
    output irq1, irq2, cfg_we, cfg_data, busy, reti,
    input  s_intr1, s_intr2, push_req, pending, in_service, int_mask, reti_err
  );

  // Interrupt-controller side.
  modport slave (
    input  irq1, irq2, cfg_we, cfg_data, busy, reti,
    output s_intr1, s_intr2, push_req, pending, in_service, int_mask, reti_err
  );

endinterface

// File: rtl/intr_pending.sv
// Rising-edge detector plus sticky pending flag for one interrupt source.
// Latency: irq rising in cycle N shows as pending in cycle N+1.
// Backpressure: pending holds until the source is dispatched; an edge coinciding with dispatch re-arms it.
module intr_pending (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic dispatch,
  output logic pending
);

  logic irq_q,  irq_d;
  logic arm_q,  arm_d;
  logic pend_q, pend_d;
  logic rise;

  // Edge detect and pending update. arm_q is low for the first cycle after
  // reset so a line already high when reset drops only reloads irq_q and
  // does not count as a new request.
  always_comb begin
    irq_d  = irq;
    arm_d  = 1'b1;
    rise   = irq & ~irq_q & arm_q;
    pend_d = (pend_q & ~dispatch) | rise;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q  <= 1'b0;
      arm_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      irq_q  <= irq_d;
      arm_q  <= arm_d;
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;

endmodule

// File: rtl/intr_controller.sv
// Two-source prioritised interrupt controller with one level of nesting (src1 over src2).
// Latency: irq rise in cycle N -> combinational s_intrX in cycle N+1 when unblocked.
// Backpressure: busy, reti, mask or service state hold the request pending; nothing is dropped.
module intr_controller
  import intr_pkg::*;
#(
  parameter int         NUM_SRC  = 2,            // only 2 is supported
  parameter logic [1:0] MASK_RST = MASK_RST_DFLT
) (
  input logic               clk,
  input logic               reset,
  intr_controller_if.slave  bus
);

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   mask_q, mask_d;
  logic                 reti_err_q, reti_err_d;
  logic [NUM_SRC-1:0]   pend;
  logic [NUM_SRC-1:0]   disp;
  logic                 gate;
  logic                 s1;
  logic                 s2;

  // Per-source edge detector and pending flag.
  intr_pending u_pend1 (
    .clk      (clk),
    .reset    (reset),
    .irq      (bus.irq1),
    .dispatch (disp[SRC1]),
    .pending  (pend[SRC1])
  );

  intr_pending u_pend2 (
    .clk      (clk),
    .reset    (reset),
    .irq      (bus.irq2),
    .dispatch (disp[SRC2]),
    .pending  (pend[SRC2])
  );

  // Dispatch decision: source 1 wins; nothing fires during a stack/PC
  // instruction, a return, or reset.
  always_comb begin
    gate = ~bus.busy & ~bus.reti & ~reset;
    s1   = pend[SRC1] & mask_q[SRC1] & src_allowed(state_q, SRC1) & gate;
    s2   = pend[SRC2] & mask_q[SRC2] & src_allowed(state_q, SRC2) & gate & ~s1;
    disp = '0;
    disp[SRC1] = s1;
    disp[SRC2] = s2;
  end

  // Next service state and sticky reti error. Dispatch and reti never
  // coincide because reti blocks dispatch.
  always_comb begin
    state_d    = state_q;
    reti_err_d = reti_err_q;
    case (state_q)
      IDLE: begin
        if (s1)            state_d = SRV1;
        else if (s2)       state_d = SRV2;
        else if (bus.reti) reti_err_d = 1'b1;
      end
      SRV2: begin
        if (s1)            state_d = SRV1_OVER2;
        else if (bus.reti) state_d = IDLE;
      end
      SRV1: begin
        if (bus.reti)      state_d = IDLE;
      end
      SRV1_OVER2: begin
        if (bus.reti)      state_d = SRV2;
      end
      default:             state_d = IDLE;
    endcase
  end

  // Mask register: a write lands at the next edge, so same-cycle dispatch
  // still sees the old mask.
  always_comb begin
    mask_d = mask_q;
    if (bus.cfg_we) mask_d = bus.cfg_data;
  end

  // Controller state registers with synchronous reset; reset also drops any
  // nesting so no reti is owed afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mask_q     <= MASK_RST;
      reti_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      reti_err_q <= reti_err_d;
    end
  end

  assign bus.s_intr1    = s1;
  assign bus.s_intr2    = s2;
  assign bus.push_req   = s1 | s2;
  assign bus.pending    = pend;
  assign bus.in_service = svc_of(state_q);
  assign bus.int_mask   = mask_q;
  assign bus.reti_err   = reti_err_q;

  // The two dispatch strobes must be mutually exclusive.
  a_onehot_dispatch: assert property (@(posedge clk) !(s1 && s2));

endmodule

// File: tb/tb_intr_controller.sv
// Directed scoreboard bench for intr_controller.
// Latency: one step per clock; inputs driven #1 after posedge, outputs sampled on negedge.
// Backpressure: n/a.
module tb_intr_controller;

  logic clk;
  logic reset;

  intr_controller_if ifc ();

  intr_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_chk;
  int n_pass;

  // Counts one comparison and reports it if it differs.
  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got s1,s2,push,pend,svc,mask,err=%b required %b", tag, obs, exp);
  endtask

  // Expected output vector {s1, s2, push, pending, in_service, mask, reti_err}.
  function automatic logic [9:0] ev(input logic s1, input logic s2, input logic [1:0] pend,
                                    input logic [1:0] svc, input logic [1:0] mask, input logic err);
    return {s1, s2, s1 | s2, pend, svc, mask, err};
  endfunction

  // Drive one cycle of inputs, queue the expectation, compare at negedge.
  task automatic step(input string tag, input logic rst, input logic i1, input logic i2,
                      input logic we, input logic [1:0] dat, input logic bsy, input logic rt,
                      input logic s1, input logic s2, input logic [1:0] pend,
                      input logic [1:0] svc, input logic [1:0] mask, input logic err);
    sb_entry_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    ifc.irq1     = i1;
    ifc.irq2     = i2;
    ifc.cfg_we   = we;
    ifc.cfg_data = dat;
    ifc.busy     = bsy;
    ifc.reti     = rt;
    e.tag = tag;
    e.exp = ev(s1, s2, pend, svc, mask, err);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk(e.tag, {ifc.s_intr1, ifc.s_intr2, ifc.push_req, ifc.pending,
                ifc.in_service, ifc.int_mask, ifc.reti_err}, e.exp);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    ifc.irq1 = 1'b0; ifc.irq2 = 1'b0; ifc.cfg_we = 1'b0;
    ifc.cfg_data = 2'b00; ifc.busy = 1'b0; ifc.reti = 1'b0;

    //    tag            rst i1 i2 we dat   bsy rt | s1 s2 pend   svc    mask   err
    step("reset",        1, 0, 0, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b00, 0);
    // single source 1 request
    step("mask_wr",      0, 0, 0, 1, 2'b11, 0, 0,  0, 0, 2'b00, 2'b00, 2'b00, 0);
    step("mask_11",      0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b11, 0);
    step("irq1_rise",    0, 1, 0, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b11, 0);
    step("s1_fire",      0, 1, 0, 0, 2'b00, 0, 0,  1, 0, 2'b01, 2'b00, 2'b11, 0);
    step("srv1_held",    0, 1, 0, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b01, 2'b11, 0);
    step("reti_srv1",    0, 0, 0, 0, 2'b00, 0, 1,  0, 0, 2'b00, 2'b01, 2'b11, 0);
    step("idle_again",   0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b11, 0);
    // simultaneous requests
    step("both_rise",    0, 1, 1, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b11, 0);
    step("prio_s1",      0, 1, 1, 0, 2'b00, 0, 0,  1, 0, 2'b11, 2'b00, 2'b11, 0);
    step("p2_held_a",    0, 1, 1, 0, 2'b00, 0, 0,  0, 0, 2'b10, 2'b01, 2'b11, 0);
    step("p2_held_b",    0, 1, 1, 0, 2'b00, 0, 0,  0, 0, 2'b10, 2'b01, 2'b11, 0);
    step("reti_gate",    0, 1, 1, 0, 2'b00, 0, 1,  0, 0, 2'b10, 2'b01, 2'b11, 0);
    step("s2_after",     0, 1, 1, 0, 2'b00, 0, 0,  0, 1, 2'b10, 2'b00, 2'b11, 0);
    step("srv2",         0, 1, 1, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b10, 2'b11, 0);
    // nesting: source 1 preempts source 2
    step("drop_lines",   0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b10, 2'b11, 0);
    step("irq1_nest",    0, 1, 0, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b10, 2'b11, 0);
    step("s1_preempt",   0, 1, 0, 0, 2'b00, 0, 0,  1, 0, 2'b01, 2'b10, 2'b11, 0);
    step("over2",        0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b11, 2'b11, 0);
    step("reti_over2",   0, 0, 0, 0, 2'b00, 0, 1,  0, 0, 2'b00, 2'b11, 2'b11, 0);
    step("back_srv2",    0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b10, 2'b11, 0);
    step("reti_srv2",    0, 0, 0, 0, 2'b00, 0, 1,  0, 0, 2'b00, 2'b10, 2'b11, 0);
    step("nest_done",    0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b11, 0);
    // masked source waits for enable
    step("mask_off_wr",  0, 0, 0, 1, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b11, 0);
    step("irq2_masked",  0, 0, 1, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b00, 0);
    step("p2_masked",    0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 2'b10, 2'b00, 2'b00, 0);
    step("mask_wr_old",  0, 0, 0, 1, 2'b10, 0, 0,  0, 0, 2'b10, 2'b00, 2'b00, 0);
    step("s2_unmasked",  0, 0, 0, 0, 2'b00, 0, 0,  0, 1, 2'b10, 2'b00, 2'b10, 0);
    step("srv2_m",       0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b10, 2'b10, 0);
    step("reti_m",       0, 0, 0, 0, 2'b00, 0, 1,  0, 0, 2'b00, 2'b10, 2'b10, 0);
    step("idle_m",       0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b10, 0);
    // busy holds dispatch
    step("mask_all_wr",  0, 0, 0, 1, 2'b11, 0, 0,  0, 0, 2'b00, 2'b00, 2'b10, 0);
    step("irq1_b",       0, 1, 0, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b11, 0);
    step("busy_1",       0, 0, 0, 0, 2'b00, 1, 0,  0, 0, 2'b01, 2'b00, 2'b11, 0);
    step("busy_2",       0, 0, 0, 0, 2'b00, 1, 0,  0, 0, 2'b01, 2'b00, 2'b11, 0);
    step("busy_3",       0, 0, 0, 0, 2'b00, 1, 0,  0, 0, 2'b01, 2'b00, 2'b11, 0);
    step("busy_release", 0, 0, 0, 0, 2'b00, 0, 0,  1, 0, 2'b01, 2'b00, 2'b11, 0);
    step("srv1_b",       0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b01, 2'b11, 0);
    step("reti_b",       0, 0, 0, 0, 2'b00, 0, 1,  0, 0, 2'b00, 2'b01, 2'b11, 0);
    step("idle_b",       0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b11, 0);
    // spurious reti, then reset out of the nested state
    step("reti_idle",    0, 0, 0, 0, 2'b00, 0, 1,  0, 0, 2'b00, 2'b00, 2'b11, 0);
    step("err_set",      0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b11, 1);
    step("err_sticky",   0, 0, 1, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b11, 1);
    step("s2_e",         0, 0, 0, 0, 2'b00, 0, 0,  0, 1, 2'b10, 2'b00, 2'b11, 1);
    step("srv2_e",       0, 1, 0, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b10, 2'b11, 1);
    step("s1_e",         0, 1, 0, 0, 2'b00, 0, 0,  1, 0, 2'b01, 2'b10, 2'b11, 1);
    step("over2_e",      0, 1, 1, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b11, 2'b11, 1);
    step("rst_in_over2", 1, 1, 1, 0, 2'b00, 0, 0,  0, 0, 2'b10, 2'b11, 2'b11, 1);
    step("post_rst",     0, 1, 1, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b00, 0);
    step("held_no_req",  0, 1, 1, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b00, 0);
    step("mask_wr_r",    0, 1, 1, 1, 2'b11, 0, 0,  0, 0, 2'b00, 2'b00, 2'b00, 0);
    step("held_masked",  0, 1, 1, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b11, 0);
    step("irq1_fall",    0, 0, 1, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b11, 0);
    step("irq1_rerise",  0, 1, 1, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b11, 0);
    step("rst_gates_s1", 1, 1, 1, 0, 2'b00, 0, 0,  0, 0, 2'b01, 2'b00, 2'b11, 0);
    step("rst_clears",   0, 1, 1, 0, 2'b00, 0, 0,  0, 0, 2'b00, 2'b00, 2'b00, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/intr_controller.md
INTR_CONTROLLER -- requirements
Module: intr_controller

Interface
REQ-001 Parameter NUM_SRC, default 2, number of interrupt sources; only the value 2 is supported.
REQ-002 Parameter MASK_RST, default 2'b00, reset value of the enable mask (all sources disabled).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 irq1  input  1  source 1 request, level, synchronous to clk; rising edge = new request.
REQ-006 irq2  input  1  source 2 request, same rules as irq1.
REQ-007 cfg_we  input  1  mask write strobe from the control unit.
REQ-008 cfg_data  input  2  new mask; bit0 = source 1, bit1 = source 2.
REQ-009 busy  input  1  current instruction uses the stack or loads the PC (call/ret/jump); dispatch is forbidden this cycle.
REQ-010 reti  input  1  control unit decodes return-from-interrupt this cycle.
REQ-011 s_intr1  output  1  one-cycle dispatch of source 1 (selects vector 1 into PC).
REQ-012 s_intr2  output  1  one-cycle dispatch of source 2 (selects vector 2 into PC).
REQ-013 push_req  output  1  return-address push request; equals s_intr1 | s_intr2.
REQ-014 pending  output  2  registered pending flags, bit0 = source 1.
REQ-015 in_service  output  2  registered in-service flags, decoded from the state.
REQ-016 int_mask  output  2  current mask register.
REQ-017 reti_err  output  1  sticky flag: reti received while no interrupt is in service.

Function
REQ-018 Edge detect: irq_q registers each irq; edge = irq & ~irq_q; irq held high produces only one request.
REQ-019 pending_next = (pending & ~dispatched) | edge, per bit; an edge in the same cycle as dispatch of that source leaves pending set.
REQ-020 Masked sources stay pending; they dispatch once enabled.
REQ-021 Mask write takes effect at the next clk edge; dispatch in the write cycle uses the old mask.
REQ-022 Priority: source 1 > source 2; s_intr1 and s_intr2 are never high together.
REQ-023 The s_intrX outputs are combinational: s_intrX = pending[X] & int_mask[X] & allowed(state, X) & ~busy & ~reti & ~reset.
REQ-024 Latency: irq rising in cycle N (seen at the end of N) -> pending set and s_intr high in cycle N+1 if unblocked.
REQ-025 States: IDLE, SRV2, SRV1, SRV1_OVER2 (source 1 preempting source 2).
REQ-026 IDLE: s_intr1 -> SRV1; s_intr2 -> SRV2.
REQ-027 SRV2: source 1 allowed, s_intr1 -> SRV1_OVER2; source 2 blocked; reti -> IDLE.
REQ-028 SRV1: both sources blocked; reti -> IDLE.
REQ-029 SRV1_OVER2: both sources blocked; reti -> SRV2.
REQ-030 reti in IDLE: state unchanged, reti_err set; reti_err is cleared only by reset.
REQ-031 in_service mapping: IDLE = 00, SRV2 = 10, SRV1 = 01, SRV1_OVER2 = 11.

Reset
REQ-032 On reset, all of the following take effect at the next edge: state = IDLE, pending = 00, irq_q = 00, int_mask = MASK_RST, reti_err = 0.
REQ-033 While reset is high, s_intr1, s_intr2 and push_req are held at 0.
REQ-034 Reset during SRV1_OVER2 or any other service state discards all nesting; no reti is required afterwards.
REQ-035 An irq line that is high while reset deasserts creates no request until it falls and rises again, because irq_q reloads in the cycle after reset.

Structure
REQ-036 Package intr_pkg holds the state enum (IDLE, SRV2, SRV1, SRV1_OVER2), source index constants SRC1 = 0 and SRC2 = 1, and the MASK_RST default.
REQ-037 The per-source edge detector with its pending flag is one sub-module, intr_pending, instantiated twice.

Verification
REQ-038 Mask = 11; irq1 rises in cycle 5 -> s_intr1 = push_req = 1 in cycle 6 only; in_service = 01 from cycle 7; reti -> in_service = 00 in the next cycle.
REQ-039 Mask = 11; irq1 and irq2 rise in the same cycle -> s_intr1 first; pending = 10 is held; after reti, s_intr2 fires in the cycle the state is IDLE.
REQ-040 In SRV2, irq1 rises -> s_intr1 fires, in_service = 11; first reti -> 10; second reti -> 00.
REQ-041 Mask = 00; irq2 pulses -> pending = 10 and no dispatch; write mask 10 -> s_intr2 fires the cycle after the write.
REQ-042 Pending = 01 with busy = 1 for 3 cycles -> no dispatch; s_intr1 fires in the first cycle busy = 0.
REQ-043 reti in IDLE -> reti_err = 1 and stays 1; reset asserted in SRV1_OVER2 -> next cycle state = IDLE, pending = 00, reti_err = 0, mask = MASK_RST.
